// File: rtl/retx_timer_scheduler.sv
// Millisecond-tick retransmission timer bank with a 16-bit register slave and a
// round-robin expiry hand-off port toward the TCP engine.
module retx_timer_scheduler #(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 16,
   parameter int TICK_DIV = 3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        irq,
   output logic        exp_valid,
   output logic [1:0]  exp_id,
   input  logic        exp_ready
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t            state;
   logic [PW-1:0]     presc;
   logic              tick;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] irq_en;
   logic [NUM_CH-1:0] active;
   logic [NUM_CH-1:0] reload_mask;
   logic [CNT_W-1:0]  load_r  [NUM_CH];
   logic [CNT_W-1:0]  count_r [NUM_CH];
   logic [1:0]        rr;

   logic              wr;
   logic [NUM_CH-1:0] w1c;
   logic [NUM_CH-1:0] start_m;
   logic [NUM_CH-1:0] stop_m;
   logic [NUM_CH-1:0] expire_set;
   logic [NUM_CH-1:0] id_hot;
   logic [NUM_CH-1:0] hs_clear;
   logic [NUM_CH-1:0] pending_next;
   logic [NUM_CH-1:0] sel_pool;
   logic              accept;
   logic              id_still;
   logic [1:0]        next_rr;
   logic [15:0]       rd_mux;
   logic              unused_wd;

   // First set bit of pool at or above base, wrapping; smallest offset wins.
   function automatic logic [1:0] rr_pick(input logic [NUM_CH-1:0] pool,
                                          input logic [1:0]        base);
      logic [1:0] pick;
      pick = base;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (pool[c] && (c == ((int'(base) + i) % NUM_CH)))
               pick = 2'(c);
         end
      end
      return pick;
   endfunction

   assign unused_wd = ^writedata;
   assign wr        = chipselect & ~write_n;
   assign tick      = (presc == '0);
   assign w1c       = (wr && address == 4'd0) ? writedata[NUM_CH-1:0] : '0;
   assign start_m   = (wr && address == 4'd2) ? writedata[NUM_CH-1:0] : '0;
   assign stop_m    = (wr && address == 4'd3) ? writedata[NUM_CH-1:0] : '0;
   assign accept    = (state == PRESENT) & exp_valid & exp_ready;
   assign irq       = |(pending & irq_en);

   always_comb begin
      expire_set = '0;
      id_hot     = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         expire_set[c] = tick & active[c] & ~start_m[c] & ~stop_m[c] &
                         (count_r[c] <= CNT_W'(1));
         id_hot[c]     = (exp_id == 2'(c));
      end
   end

   // A fresh expiry beats any clear landing in the same cycle.
   assign hs_clear     = accept ? id_hot : '0;
   assign pending_next = (pending & ~w1c & ~hs_clear) | expire_set;
   assign sel_pool     = pending & ~w1c;
   assign id_still     = |(pending_next & id_hot);
   assign next_rr      = (exp_id == 2'(NUM_CH - 1)) ? 2'd0 : exp_id + 2'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc <= PW'(TICK_DIV - 1);
      end else if (tick) begin
         presc <= PW'(TICK_DIV - 1);
      end else begin
         presc <= presc - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            count_r[c] <= '0;
            load_r[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (start_m[c]) begin
               active[c]  <= 1'b1;
               count_r[c] <= load_r[c];
            end else if (stop_m[c]) begin
               active[c]  <= 1'b0;
            end else if (tick && active[c]) begin
               if (count_r[c] <= CNT_W'(1)) begin
                  if (reload_mask[c]) begin
                     count_r[c] <= load_r[c];
                  end else begin
                     active[c]  <= 1'b0;
                     count_r[c] <= '0;
                  end
               end else begin
                  count_r[c] <= count_r[c] - 1'b1;
               end
            end
            if (wr && address == 4'(8 + c))
               load_r[c] <= writedata[CNT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending     <= '0;
         irq_en      <= '0;
         reload_mask <= '0;
      end else begin
         pending <= pending_next;
         if (wr && address == 4'd1)
            irq_en <= writedata[NUM_CH-1:0];
         if (wr && address == 4'd4)
            reload_mask <= writedata[NUM_CH-1:0];
      end
   end

   // Expiry hand-off; a channel cleared by software in the same cycle is never selected.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         exp_valid <= 1'b0;
         exp_id    <= 2'd0;
         rr        <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (|sel_pool) begin
                  exp_id    <= rr_pick(sel_pool, rr);
                  exp_valid <= 1'b1;
                  state     <= PRESENT;
               end
            end
            PRESENT: begin
               if (exp_ready) begin
                  exp_valid <= 1'b0;
                  rr        <= next_rr;
                  state     <= IDLE;
               end else if (!id_still) begin
                  exp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               exp_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         4'd0:    rd_mux[NUM_CH-1:0] = pending;
         4'd1:    rd_mux[NUM_CH-1:0] = irq_en;
         4'd2:    rd_mux[NUM_CH-1:0] = active;
         4'd4:    rd_mux[NUM_CH-1:0] = reload_mask;
         default: rd_mux = '0;
      endcase
      for (int c = 0; c < NUM_CH; c++) begin
         if (address == 4'(8 + c))
            rd_mux = 16'(load_r[c]);
         if (address == 4'(12 + c))
            rd_mux = 16'(count_r[c]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata <= '0;
      end else begin
         readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_retx_timer_scheduler.sv
// Bench for retx_timer_scheduler: directed scenarios plus random register traffic,
// every cycle compared against a deadline-based reference model of the timer bank.
module tb_retx_timer_scheduler;

   localparam int N  = 4;
   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic        irq;
   logic        exp_valid;
   logic [1:0]  exp_id;
   logic        exp_ready;

   int n_tests = 0;
   int n_fail  = 0;

   retx_timer_scheduler #(.NUM_CH(N), .CNT_W(16), .TICK_DIV(TD)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
      .exp_valid(exp_valid), .exp_id(exp_id), .exp_ready(exp_ready)
   );

   always #5 clk = ~clk;

   // Reference model: each armed channel remembers the tick number it started at
   // and its load; expiry happens on tick number start + max(load,1).
   int       cyc, ticks;
   bit [3:0] m_act, m_pend, m_ien, m_rel;
   int       m_ld[N], m_lds[N], m_st[N], m_held[N];
   int       m_rr, m_pid;
   bit       m_pres;
   logic [15:0] m_rd;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic int cnt_view(input int c);
      if (m_act[c]) begin
         if (m_lds[c] == 0) return 0;
         return m_lds[c] - (ticks - m_st[c]);
      end
      return m_held[c];
   endfunction

   function automatic logic [15:0] model_read(input int a);
      if (a == 0) return {12'd0, m_pend};
      if (a == 1) return {12'd0, m_ien};
      if (a == 2) return {12'd0, m_act};
      if (a == 4) return {12'd0, m_rel};
      if (a >= 8 && a < 8 + N) return 16'(m_ld[a-8]);
      if (a >= 12 && a < 12 + N) return 16'(cnt_view(a-12));
      return 16'd0;
   endfunction

   task automatic model_reset();
      cyc = 0; ticks = 0;
      m_act = 0; m_pend = 0; m_ien = 0; m_rel = 0;
      m_rr = 0; m_pid = 0; m_pres = 0;
      for (int c = 0; c < N; c++) begin
         m_ld[c] = 0; m_lds[c] = 0; m_st[c] = 0; m_held[c] = 0;
      end
   endtask

   task automatic model_step();
      bit wr, tk;
      bit [3:0] w1c, st, sp, ex, acc, pool;
      int a;
      a   = int'(address);
      wr  = chipselect && !write_n;
      tk  = (cyc % TD) == TD - 1;
      w1c = 0; st = 0; sp = 0; ex = 0; acc = 0;
      m_rd = model_read(a);
      if (wr && a == 0) w1c = writedata[3:0];
      if (wr && a == 2) st  = writedata[3:0];
      if (wr && a == 3) sp  = writedata[3:0];
      pool = m_pend & ~w1c;
      for (int c = 0; c < N; c++) begin
         if (st[c]) begin
            m_act[c] = 1; m_lds[c] = m_ld[c]; m_st[c] = ticks + int'(tk);
         end else if (sp[c]) begin
            m_held[c] = cnt_view(c); m_act[c] = 0;
         end else if (tk && m_act[c] &&
                      (ticks - m_st[c] + 1 >= ((m_lds[c] > 1) ? m_lds[c] : 1))) begin
            ex[c] = 1;
            if (m_rel[c]) begin
               m_lds[c] = m_ld[c]; m_st[c] = ticks + 1;
            end else begin
               m_act[c] = 0; m_held[c] = 0;
            end
         end
      end
      if (m_pres) begin
         if (exp_ready) begin
            acc[m_pid] = 1; m_rr = (m_pid + 1) % N; m_pres = 0;
         end else if (w1c[m_pid] && !ex[m_pid]) begin
            m_pres = 0;
         end
      end else if (pool != 0) begin
         for (int i = N - 1; i >= 0; i--)
            if (pool[(m_rr + i) % N]) m_pid = (m_rr + i) % N;
         m_pres = 1;
      end
      m_pend = (m_pend & ~w1c & ~acc) | ex;
      if (wr && a == 1) m_ien = writedata[3:0];
      if (wr && a == 4) m_rel = writedata[3:0];
      if (wr && a >= 8 && a < 8 + N) m_ld[a-8] = int'(writedata);
      if (tk) ticks++;
      cyc++;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_eq("readdata", readdata, m_rd);
      check_eq("irq", 16'(irq), 16'(|(m_pend & m_ien)));
      check_eq("exp_valid", 16'(exp_valid), 16'(m_pres));
      if (m_pres) check_eq("exp_id", 16'(exp_id), 16'(m_pid));
   endtask

   task automatic idle(input int n);
      chipselect = 1'b0; write_n = 1'b1;
      repeat (n) step();
   endtask

   task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      step();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd_reg(input logic [3:0] a);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      step();
      chipselect = 1'b0;
   endtask

   task automatic wait_next_tick();
      chipselect = 1'b0; write_n = 1'b1;
      while ((cyc % TD) != TD - 1) step();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_readdata"}, readdata, 16'd0);
      check_eq({tag, "_irq"}, 16'(irq), 16'd0);
      check_eq({tag, "_exp_valid"}, 16'(exp_valid), 16'd0);
      check_eq({tag, "_exp_id"}, 16'(exp_id), 16'd0);
   endtask

   initial begin
      reset = 1'b1; address = 4'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = 16'd0; exp_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset = 1'b0;

      // Single one-shot expiry, held un-acknowledged, then accepted.
      wr_reg(4'd8, 16'd3);
      wr_reg(4'd2, 16'h1);
      address = 4'd12; idle(14);
      rd_reg(4'd0); rd_reg(4'd2); rd_reg(4'd12);
      exp_ready = 1'b1; idle(3);

      // Auto-reload on channel 1, five expiries accepted immediately.
      wr_reg(4'd4, 16'h2);
      wr_reg(4'd9, 16'd2);
      wr_reg(4'd2, 16'h2);
      address = 4'd2; idle(5 * 2 * TD + 2);
      wr_reg(4'd3, 16'h2);
      wr_reg(4'd4, 16'h0);
      idle(4);

      // All four channels expire on one tick; then a round with rr=2 and pending 0x5.
      for (int c = 0; c < N; c++) wr_reg(4'(8 + c), 16'd1);
      exp_ready = 1'b0;
      wait_next_tick();
      wr_reg(4'd2, 16'hF);
      address = 4'd0; idle(2 * TD);
      exp_ready = 1'b1; idle(10);
      wr_reg(4'd2, 16'h2);
      idle(2 * TD);
      exp_ready = 1'b0;
      wr_reg(4'd2, 16'h5);
      idle(2 * TD);
      exp_ready = 1'b1; idle(6);

      // STOP on channel 2 in the tick where its count is 1, then restart.
      wr_reg(4'd10, 16'd2);
      wait_next_tick();
      wr_reg(4'd2, 16'h4);
      wait_next_tick();
      step();
      wait_next_tick();
      wr_reg(4'd3, 16'h4);
      for (int k = 0; k < 2 * TD; k++) rd_reg(4'd14);
      rd_reg(4'd0);
      wr_reg(4'd2, 16'h4);
      rd_reg(4'd14);
      idle(3 * TD);

      // Interrupt mask, then software clear while the expiry is presented.
      wr_reg(4'd1, 16'h1);
      exp_ready = 1'b0;
      wr_reg(4'd8, 16'd1);
      wr_reg(4'd2, 16'h1);
      idle(TD + 2);
      wr_reg(4'd0, 16'h1);
      idle(3);

      // Reset while an expiry is presented and channel 3 is armed.
      wr_reg(4'd11, 16'd9);
      wr_reg(4'd2, 16'h8);
      wr_reg(4'd2, 16'h1);
      idle(TD + 2);
      check_eq("pre_reset_valid", 16'(exp_valid), 16'd1);
      #2 reset = 1'b1;
      #1 check_reset_outputs("midrst");
      @(posedge clk); @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      rd_reg(4'd2); rd_reg(4'd15); rd_reg(4'd0);
      idle(6 * TD);

      // Random register traffic with random back-pressure.
      exp_ready = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         address    = 4'($urandom_range(0, 15));
         chipselect = ($urandom_range(0, 1) == 1);
         write_n    = ($urandom_range(0, 3) != 0);
         exp_ready  = ($urandom_range(0, 1) == 1);
         if (address >= 4'd8 && address < 4'd12)
            writedata = 16'($urandom_range(0, 6));
         else if (address == 4'd3)
            writedata = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(0, 15)) : 16'd0;
         else
            writedata = 16'($urandom);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
